// File: rtl/csr_pkg.sv
// Shared CSR address map, operation encodings and FSM state type for the CSR unit.
package csr_pkg;

  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  typedef enum logic [1:0] {
    OP_ILL = 2'b00,
    OP_RW  = 2'b01,
    OP_RS  = 2'b10,
    OP_RC  = 2'b11
  } csr_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_CAPTURE,
    ST_WRITE,
    ST_DONE
  } csr_state_t;

endpackage

// File: rtl/csr_alu.sv
// New-value compute for CSRRW/CSRRS/CSRRC plus the write-enable and
// read-only/illegal-op decision for the latched request.
module csr_alu
  import csr_pkg::*;
(
  input  csr_op_t     op_i,
  input  logic [11:0] addr_i,
  input  logic [31:0] rd_i,
  input  logic [31:0] wdata_i,
  input  logic        wr_suppress_i,
  output logic [31:0] wr_val_o,
  output logic        we_o,
  output logic        illegal_o
);

  logic attempt;
  logic read_only;

  always_comb begin
    attempt   = (op_i == OP_RW) || (((op_i == OP_RS) || (op_i == OP_RC)) && !wr_suppress_i);
    read_only = (addr_i[11:10] == 2'b11);

    case (op_i)
      OP_RS:   wr_val_o = rd_i | wdata_i;
      OP_RC:   wr_val_o = rd_i & ~wdata_i;
      default: wr_val_o = wdata_i;
    endcase
    // Both trap vectors are word aligned; the low bits are hardwired to zero.
    if ((addr_i == CSR_MTVEC) || (addr_i == CSR_MEPC)) begin
      wr_val_o[1:0] = 2'b00;
    end

    illegal_o = (op_i == OP_ILL) || (attempt && read_only);
    we_o      = attempt && !read_only;
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR access unit: req/ack sequencer over the counter CSRs and
// the local mscratch/mtvec/mepc/mcause registers.
//   state   | meaning
//   IDLE    | wait for req, latch addr/op/wdata, drive counter select
//   SEL     | counter select settling
//   CAPTURE | register old value into rd, flag unknown address
//   WRITE   | commit new value or flag illegal write
//   DONE    | present rdata/illegal with a one-cycle ack
module csr_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [11:0] addr,
  input  logic [1:0]  op,
  input  logic [31:0] wdata,
  input  logic        wr_suppress,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        illegal,
  output logic        instret_sel,
  input  logic [31:0] instret_data,
  output logic        cycle_sel,
  input  logic [31:0] cycle_data
);

  csr_state_t  state_q;
  logic [11:0] addr_q;
  csr_op_t     op_q;
  logic [31:0] wdata_q;
  logic        wsup_q;
  logic [31:0] rd_q;
  logic        ill_q;
  logic        ack_q;
  logic [31:0] rdata_q;
  logic        illegal_q;
  logic        instret_sel_q;
  logic        cycle_sel_q;
  logic [31:0] mscratch_q;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;

  logic [31:0] rd_d;
  logic        unknown_d;
  logic [31:0] wr_val_d;
  logic        we_d;
  logic        alu_ill_d;

  always_comb begin
    rd_d      = '0;
    unknown_d = 1'b0;
    case (addr_q)
      CSR_CYCLE, CSR_CYCLEH:     rd_d = cycle_data;
      CSR_INSTRET, CSR_INSTRETH: rd_d = instret_data;
      CSR_MSCRATCH:              rd_d = mscratch_q;
      CSR_MTVEC:                 rd_d = mtvec_q;
      CSR_MEPC:                  rd_d = mepc_q;
      CSR_MCAUSE:                rd_d = mcause_q;
      CSR_MHARTID:               rd_d = HART_ID;
      default:                   unknown_d = 1'b1;
    endcase
  end

  csr_alu u_alu (
    .op_i          (op_q),
    .addr_i        (addr_q),
    .rd_i          (rd_q),
    .wdata_i       (wdata_q),
    .wr_suppress_i (wsup_q),
    .wr_val_o      (wr_val_d),
    .we_o          (we_d),
    .illegal_o     (alu_ill_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      op_q          <= OP_ILL;
      wdata_q       <= '0;
      wsup_q        <= 1'b0;
      rd_q          <= '0;
      ill_q         <= 1'b0;
      ack_q         <= 1'b0;
      rdata_q       <= '0;
      illegal_q     <= 1'b0;
      instret_sel_q <= 1'b0;
      cycle_sel_q   <= 1'b0;
      mscratch_q    <= '0;
      mtvec_q       <= MTVEC_RESET;
      mepc_q        <= '0;
      mcause_q      <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A req still high during the ack cycle belongs to the finished access.
          if (req && !ack_q) begin
            addr_q        <= addr;
            op_q          <= csr_op_t'(op);
            wdata_q       <= wdata;
            wsup_q        <= wr_suppress;
            instret_sel_q <= ((addr == CSR_INSTRET) || (addr == CSR_INSTRETH)) && addr[7];
            cycle_sel_q   <= ((addr == CSR_CYCLE) || (addr == CSR_CYCLEH)) && addr[7];
            state_q       <= ST_SEL;
          end
        end
        ST_SEL: state_q <= ST_CAPTURE;
        ST_CAPTURE: begin
          rd_q          <= rd_d;
          ill_q         <= unknown_d;
          instret_sel_q <= 1'b0;
          cycle_sel_q   <= 1'b0;
          state_q       <= ST_WRITE;
        end
        ST_WRITE: begin
          if (we_d && !ill_q) begin
            case (addr_q)
              CSR_MSCRATCH: mscratch_q <= wr_val_d;
              CSR_MTVEC:    mtvec_q    <= wr_val_d;
              CSR_MEPC:     mepc_q     <= wr_val_d;
              CSR_MCAUSE:   mcause_q   <= wr_val_d;
              default:      ;
            endcase
          end
          ill_q   <= ill_q | alu_ill_d;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          ack_q     <= 1'b1;
          rdata_q   <= rd_q;
          illegal_q <= ill_q;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign illegal     = illegal_q;
  assign instret_sel = instret_sel_q;
  assign cycle_sel   = cycle_sel_q;

endmodule

// File: tb/tb_csr_unit.sv
// Directed plus randomized bench for csr_unit against an architectural CSR model.
module tb_csr_unit;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0100;
  localparam logic [31:0] HART      = 32'h0000_0007;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [11:0] addr;
  logic [1:0]  op;
  logic [31:0] wdata;
  logic        wr_suppress;
  logic        ack;
  logic [31:0] rdata;
  logic        illegal;
  logic        instret_sel;
  logic [31:0] instret_data;
  logic        cycle_sel;
  logic [31:0] cycle_data;

  logic [63:0] cyc64;
  logic [63:0] ins64;
  logic [31:0] m_scratch, m_tvec, m_epc, m_cause;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign cycle_data   = cycle_sel   ? cyc64[63:32] : cyc64[31:0];
  assign instret_data = instret_sel ? ins64[63:32] : ins64[31:0];

  csr_unit #(.MTVEC_RESET(MTVEC_RST), .HART_ID(HART)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .addr         (addr),
    .op           (op),
    .wdata        (wdata),
    .wr_suppress  (wr_suppress),
    .ack          (ack),
    .rdata        (rdata),
    .illegal      (illegal),
    .instret_sel  (instret_sel),
    .instret_data (instret_data),
    .cycle_sel    (cycle_sel),
    .cycle_data   (cycle_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_scratch = 32'h0;
    m_tvec    = MTVEC_RST;
    m_epc     = 32'h0;
    m_cause   = 32'h0;
  endtask

  // Architectural view: what a legal CSR instruction returns and leaves behind.
  task automatic model(input logic [11:0] a, input logic [1:0] o, input logic [31:0] wd,
                       input logic ws, output logic [31:0] er, output logic ei,
                       output logic esi, output logic esc);
    logic [31:0] old, nv;
    bit known, attempt, ro;
    known = 1; esi = 0; esc = 0; old = 32'h0;
    case (a)
      12'hC00: old = cyc64[31:0];
      12'hC80: begin old = cyc64[63:32]; esc = 1; end
      12'hC02: old = ins64[31:0];
      12'hC82: begin old = ins64[63:32]; esi = 1; end
      12'h340: old = m_scratch;
      12'h305: old = m_tvec;
      12'h341: old = m_epc;
      12'h342: old = m_cause;
      12'hF14: old = HART;
      default: known = 0;
    endcase
    attempt = (o == 2'd1) || ((o == 2'd2 || o == 2'd3) && !ws);
    ro      = (a >= 12'hC00);
    ei      = !known || (o == 2'd0) || (attempt && ro);
    er      = old;
    if (!ei && attempt) begin
      case (o)
        2'd1:    nv = wd;
        2'd2:    nv = old | wd;
        default: nv = old & ~wd;
      endcase
      if (a == 12'h305 || a == 12'h341) nv = nv & 32'hFFFF_FFFC;
      case (a)
        12'h340: m_scratch = nv;
        12'h305: m_tvec    = nv;
        12'h341: m_epc     = nv;
        12'h342: m_cause   = nv;
        default: ;
      endcase
    end
  endtask

  task automatic txn(input logic [11:0] a, input logic [1:0] o, input logic [31:0] wd,
                     input logic ws, input bit drop, input string tag);
    logic [31:0] er;
    logic ei, esi, esc;
    model(a, o, wd, ws, er, ei, esi, esc);
    @(negedge clk);
    addr = a; op = o; wdata = wd; wr_suppress = ws; req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check({tag, " ack"}, {31'b0, ack}, {31'b0, (k == 5)});
      if (k <= 2) begin
        check({tag, " isel"}, {31'b0, instret_sel}, {31'b0, esi});
        check({tag, " csel"}, {31'b0, cycle_sel}, {31'b0, esc});
      end
      if (k == 3) check({tag, " sel_off"}, {30'b0, instret_sel, cycle_sel}, 32'h0);
      if (k == 1 && drop) begin
        req = 1'b0; addr = 12'($urandom); op = 2'($urandom); wdata = $urandom;
      end
      if (k == 5) begin
        check({tag, " rdata"}, rdata, er);
        check({tag, " illegal"}, {31'b0, illegal}, {31'b0, ei});
        req = 1'b0;
      end
    end
    @(posedge clk); #1;
    check({tag, " ack_drop"}, {31'b0, ack}, 32'h0);
  endtask

  initial begin
    logic [11:0] valid_addrs [9];
    logic [11:0] ra;
    valid_addrs = '{12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h340, 12'h305, 12'h341, 12'h342, 12'hF14};

    rst = 1'b1; req = 1'b0; addr = '0; op = '0; wdata = '0; wr_suppress = 1'b0;
    cyc64 = 64'h0; ins64 = 64'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst ack", {31'b0, ack}, 32'h0);
    check("rst illegal", {31'b0, illegal}, 32'h0);
    check("rst rdata", rdata, 32'h0);
    check("rst sels", {30'b0, instret_sel, cycle_sel}, 32'h0);
    @(negedge clk) rst = 1'b0;

    txn(12'h305, 2'b10, 32'h0, 1'b1, 0, "mtvec_rst");
    txn(12'h340, 2'b01, 32'hDEADBEEF, 1'b0, 0, "mscr_rw");
    txn(12'h340, 2'b10, 32'h0000_0010, 1'b0, 1, "mscr_rs");
    txn(12'h340, 2'b10, 32'h0, 1'b1, 0, "mscr_rd");
    txn(12'h341, 2'b01, 32'h80, 1'b0, 0, "mepc_rw");
    txn(12'h341, 2'b11, 32'h0, 1'b1, 0, "mepc_rc_sup");
    txn(12'h341, 2'b01, 32'h83, 1'b0, 0, "mepc_rw83");
    txn(12'h341, 2'b10, 32'h0, 1'b1, 0, "mepc_rd");
    ins64 = 64'h1_0000_0005;
    cyc64 = 64'h0000_0042_1234_5678;
    txn(12'hC82, 2'b10, 32'h0, 1'b1, 0, "instreth");
    txn(12'hC02, 2'b10, 32'h0, 1'b1, 0, "instret");
    txn(12'hC80, 2'b10, 32'h0, 1'b1, 0, "cycleh");
    txn(12'hC00, 2'b01, 32'h1, 1'b0, 0, "cycle_wr");
    txn(12'h7FF, 2'b10, 32'h0, 1'b1, 0, "unknown");
    txn(12'h340, 2'b00, 32'hFFFF_FFFF, 1'b0, 0, "op00");
    txn(12'h340, 2'b10, 32'h0, 1'b1, 0, "op00_rd");
    txn(12'hF14, 2'b10, 32'h0, 1'b1, 0, "hartid");
    txn(12'h305, 2'b01, 32'hFFFF_FFFF, 1'b0, 0, "mtvec_rw");
    txn(12'h305, 2'b10, 32'h0, 1'b1, 0, "mtvec_rd");

    // Reset lands while the RW to mcause sits in WRITE; the write must not happen.
    @(negedge clk);
    addr = 12'h342; op = 2'b01; wdata = 32'hA; wr_suppress = 1'b0; req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; req = 1'b0;
    #1;
    check("abort ack", {31'b0, ack}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("abort no_ack", {31'b0, ack}, 32'h0);
    end
    @(negedge clk) rst = 1'b0;
    model_reset();
    txn(12'h342, 2'b10, 32'h0, 1'b1, 0, "mcause_after_rst");
    txn(12'h342, 2'b01, 32'h5, 1'b0, 0, "mcause_rw");
    txn(12'h342, 2'b10, 32'h0, 1'b1, 0, "mcause_rd");

    for (int i = 0; i < 60; i++) begin
      cyc64 = {$urandom, $urandom};
      ins64 = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) ra = 12'($urandom);
      else ra = valid_addrs[$urandom_range(0, 8)];
      txn(ra, 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Machine-mode CSR access unit that sits directly downstream of the counter CSRs (instret and cycle).
- Executes CSRRW/CSRRS/CSRRC requests from the execute stage using a req/ack handshake.
- Drives the word-select line of each counter and registers its 32-bit read half.
- Holds mscratch, mtvec, mepc and mcause locally and flags illegal accesses.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
- HART_ID, 0, value returned for mhartid (0xF14).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- req  in  1  access request; held high until ack
- addr  in  12  CSR address, sampled when req is seen in IDLE
- op  in  2  01=RW, 10=RS, 11=RC; 00 is illegal
- wdata  in  32  operand (rs1 value or zimm), sampled with addr
- wr_suppress  in  1  high when rs1=x0 (RS/RC) so no write occurs
- ack  out  1  one-cycle completion pulse
- rdata  out  32  old CSR value, valid while ack is high
- illegal  out  1  valid while ack is high; unknown CSR or write to a read-only CSR
- instret_sel  out  1  counter half select, 1=high word
- instret_data  in  32  instret counter word
- cycle_sel  out  1  counter half select, 1=high word
- cycle_data  in  32  cycle counter word

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; ack=0; illegal=0; rdata=0; both sel outputs=0.
  - mscratch=0, mepc=0, mcause=0, mtvec=MTVEC_RESET.
- FSM states IDLE -> SEL -> CAPTURE -> WRITE -> DONE -> IDLE.
- IDLE:
  - When req=1, latch addr, op and wdata.
  - Decode the latched address and go to SEL.
- SEL:
  - Drive instret_sel/cycle_sel = addr[7] for the counter addresses below; they stay 0 for all other addresses.
  - Hold the select through CAPTURE.
- CAPTURE:
  - Register the old value into an internal rd register.
    - 0xC00 -> cycle_data, 0xC80 -> cycle_data (high word).
    - 0xC02 -> instret_data, 0xC82 -> instret_data (high word).
    - 0x340 mscratch, 0x305 mtvec, 0x341 mepc, 0x342 mcause.
    - 0xF14 -> HART_ID.
  - Any other address: rd=0 and the illegal flag is set.
- WRITE:
  - New value by op: RW = wdata; RS = rd | wdata; RC = rd & ~wdata.
  - A write is attempted unless wr_suppress=1 with op RS/RC. RW always writes.
  - Attempted write to a read-only address (addr[11:10]==2'b11) sets illegal and leaves state unchanged.
  - mtvec bits [1:0] are forced to 00; mepc bits [1:0] are forced to 00.
  - op=00 sets illegal and performs no write.
- DONE:
  - ack=1 for exactly one cycle; rdata=rd; illegal is valid.
  - Return to IDLE next cycle.
- Latency: req seen at edge N gives ack high in the cycle after edge N+4. Fixed 5-cycle occupancy.
- Back-to-back: if req is still high in the IDLE cycle after ack, it is a new request. The requester must drop req in the ack cycle.
- req dropping mid-transaction is ignored: the transaction completes.
- Illegal accesses still ack and never modify any register.
- Counter reads are not 64-bit atomic. Software reads high, low, high and retries on mismatch.
- Reset asserted mid-transaction aborts it with no ack, even if the state was WRITE.

Decomposition:
- Package csr_pkg holds:
  - the CSR address constants;
  - the op encodings as a csr_op_t enum;
  - the FSM state enum csr_state_t.
- Sub-module csr_alu: combinational RW/RS/RC new-value compute plus read-only and write-enable decision.

Test Plan:
- Reset with MTVEC_RESET=32'h100, then read 0x305 -> rdata=32'h100, illegal=0, ack exactly 5 cycles after req.
- RW 0x340 with 32'hDEADBEEF, then RS 0x340 with 32'h0000_0010, then read -> second rdata=DEADBEEF, final value DEADBEFF.
- RC 0x341 with wdata 0 and wr_suppress=1 after mepc was set to 32'h80 -> rdata=32'h80, mepc unchanged; RW 0x341 with 32'h83 -> mepc=32'h80.
- Stub instret with 64'h1_0000_0005: read 0xC82 -> instret_sel=1 in SEL/CAPTURE, rdata=1; read 0xC02 -> rdata=5.
- RW 0xC00 with 32'h1 -> illegal=1, rdata=cycle_data low word; address 0x7FF -> illegal=1, rdata=0; op=00 -> illegal=1.
- Assert rst during WRITE of RW 0x342 with 32'hA -> no ack, mcause=0, state IDLE; the next request completes normally.
